// File: rtl/button_conditioner_if.sv
// Bus carrying raw keys into the button conditioner and its conditioned outputs back out.
// The conditioner itself connects through the slave modport.
interface button_conditioner_if #(
   parameter int N_BTN = 2
);
   logic [N_BTN-1:0] btn_n;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic             combo_active;
   logic             combo_reset;

   modport master (
      output btn_n,
      input  btn_level, btn_press, btn_release, combo_active, combo_reset
   );

   modport slave (
      input  btn_n,
      output btn_level, btn_press, btn_release, combo_active, combo_reset
   );
endinterface

// File: rtl/button_conditioner.sv
// N-channel push-button front end: synchroniser, debounce, press/release pulses and a held-combo reset.
// Optional auto-repeat of press pulses is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner #(
   parameter int               N_BTN         = 2,
   parameter int               DEBOUNCE_CYC  = 16,
   parameter logic [N_BTN-1:0] COMBO_MASK    = '1,
   parameter int               COMBO_HOLD    = 8,
   parameter int               REPEAT_DELAY  = 10,
   parameter int               REPEAT_PERIOD = 5
) (
   input logic                 Clk,
   input logic                 Reset,
   button_conditioner_if.slave bus
);

   localparam int DB_W = $clog2(DEBOUNCE_CYC);
   localparam int CC_W = $clog2(COMBO_HOLD + 1);
   // The IDLE cycle that detects the combo counts as the first held cycle.
   localparam int FIRE_AT = (COMBO_HOLD >= 2) ? COMBO_HOLD - 2 : 0;

   if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
      $error("button_conditioner: DEBOUNCE_CYC must be >= 2");
   end
   if (COMBO_HOLD < 1 || COMBO_MASK == '0) begin : g_bad_combo
      $error("button_conditioner: COMBO_HOLD must be >= 1 and COMBO_MASK nonzero");
   end
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
      $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, ARM, FIRED} combo_state_t;

   logic [N_BTN-1:0] sync1, sync2, sync;
   logic [N_BTN-1:0] level, press_q, release_q;
   logic [DB_W-1:0]  cnt [N_BTN];
   logic [N_BTN-1:0] rep_pulse;
   logic [N_BTN-1:0] press_out, release_out;
   logic [CC_W-1:0]  combo_cnt;
   combo_state_t     state, state_next;
   logic             held, mask_any, fire, active;

   assign sync = ~sync2;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1     <= '1;
         sync2     <= '1;
         level     <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
      end else begin
         sync1     <= bus.btn_n;
         sync2     <= sync1;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            if (sync[i] == level[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
               level[i]     <= sync[i];
               press_q[i]   <= sync[i];
               release_q[i] <= ~sync[i];
               cnt[i]       <= '0;
            end else begin
               cnt[i] <= cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign held     = ((level & COMBO_MASK) == COMBO_MASK);
   assign mask_any = |(level & COMBO_MASK);
   assign fire     = (state == ARM) && held && (combo_cnt == CC_W'(FIRE_AT));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         combo_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == ARM && held) combo_cnt <= combo_cnt + CC_W'(1);
         else                      combo_cnt <= '0;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (held) state_next = ARM;
         ARM:     if (!held) state_next = IDLE;
                  else if (fire) state_next = FIRED;
         FIRED:   if (!mask_any) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int RP_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
   logic [RP_W-1:0] rep_cnt [N_BTN];

   // The counter parks on REPEAT_DELAY after each period so every repeat hits one compare value.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < N_BTN; i++) rep_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (!level[i])
               rep_cnt[i] <= '0;
            else if (rep_cnt[i] == RP_W'(REPEAT_DELAY + REPEAT_PERIOD - 1))
               rep_cnt[i] <= RP_W'(REPEAT_DELAY);
            else
               rep_cnt[i] <= rep_cnt[i] + RP_W'(1);
         end
      end
   end

   always_comb begin
      rep_pulse = '0;
      for (int i = 0; i < N_BTN; i++)
         rep_pulse[i] = level[i] && (rep_cnt[i] == RP_W'(REPEAT_DELAY)) &&
                        !(COMBO_MASK[i] && state != IDLE);
   end
`else
   assign rep_pulse = '0;
`endif

   always_comb begin
      active      = (state == FIRED);
      press_out   = press_q | rep_pulse;
      release_out = release_q & ~({N_BTN{active}} & COMBO_MASK);
   end

   assign bus.btn_level    = level;
   assign bus.btn_press    = press_out;
   assign bus.btn_release  = release_out;
   assign bus.combo_active = active;
   assign bus.combo_reset  = fire;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected pulse events are queued when keys are driven
// and matched against observed pulses, plus inline level/combo_active checks per scenario.
module tb_button_conditioner;

   localparam int N = 2;

   typedef struct {
      int kind;
      int ch;
      int cyc;
   } ev_t;

   logic Clk = 1'b0;
   logic Reset;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   ev_t  sb [$];

   button_conditioner_if #(.N_BTN(N)) bus ();

   button_conditioner #(
      .N_BTN(N), .DEBOUNCE_CYC(4), .COMBO_MASK(2'b11), .COMBO_HOLD(8),
      .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .bus(bus)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   // Every observed pulse must match the oldest queued expectation in kind, channel and cycle.
   always @(negedge Clk) begin : monitor
      bit  hit;
      ev_t e;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < N; i++) begin
            hit = (k == 0) ? bus.btn_press[i] === 1'b1 :
                  (k == 1) ? bus.btn_release[i] === 1'b1 :
                             (i == 0 && bus.combo_reset === 1'b1);
            if (hit) begin
               checks++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("[TB] FAIL unexpected_event: got kind=%0d ch=%0d at cycle %0d, required none", k, i, cyc);
               end else begin
                  e = sb.pop_front();
                  if (e.kind !== k || e.ch !== i || e.cyc !== cyc) begin
                     failures++;
                     $display("[TB] FAIL event_match: got kind=%0d ch=%0d cyc=%0d, required kind=%0d ch=%0d cyc=%0d",
                              k, i, cyc, e.kind, e.ch, e.cyc);
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic go_to(input int t);
      while (cyc < t) @(negedge Clk);
   endtask

   task automatic push(input int kind, input int ch, input int at);
      ev_t e;
      e.kind = kind;
      e.ch   = ch;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      int c, r;
      Reset = 1'b1;
      bus.btn_n = 2'b00;
      repeat (2) @(negedge Clk);
      checks++;
      if (bus.btn_level !== 2'b00 || bus.btn_press !== 2'b00 || bus.btn_release !== 2'b00 ||
          bus.combo_active !== 1'b0 || bus.combo_reset !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got lvl=%b prs=%b rel=%b act=%b rst=%b, required all 0",
                  bus.btn_level, bus.btn_press, bus.btn_release, bus.combo_active, bus.combo_reset);
      end
      Reset = 1'b0;
      c = cyc;
      push(0, 0, c + 6);
      push(0, 1, c + 6);
      push(2, 0, c + 13);
      go_to(c + 5);
      checks++;
      if (bus.btn_level !== 2'b00) begin
         failures++;
         $display("[TB] FAIL reset_level_early: got %b required 00", bus.btn_level);
      end
      go_to(c + 6);
      checks++;
      if (bus.btn_level !== 2'b11) begin
         failures++;
         $display("[TB] FAIL reset_level_latency: got %b required 11", bus.btn_level);
      end
      go_to(c + 20);
      r = cyc;
      bus.btn_n = 2'b11;
      go_to(r + 6);
      checks++;
      if (bus.btn_level !== 2'b00 || bus.combo_active !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_release: got lvl=%b act=%b required lvl=00 act=1", bus.btn_level, bus.combo_active);
      end
      go_to(r + 7);
      checks++;
      if (bus.combo_active !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_combo_idle: got %b required 0", bus.combo_active);
      end
      go_to(r + 12);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL reset_pending: got %0d events outstanding required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_bounce();
      int c, last, r;
      c = cyc;
      bus.btn_n[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         repeat (2) @(negedge Clk);
         bus.btn_n[0] = ~bus.btn_n[0];
      end
      last = cyc;
      push(0, 0, last + 6);
      go_to(last + 5);
      checks++;
      if (bus.btn_level[0] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bounce_level_early: got %b required 0", bus.btn_level[0]);
      end
      go_to(last + 6);
      checks++;
      if (bus.btn_level[0] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bounce_level: got %b required 1", bus.btn_level[0]);
      end
      go_to(last + 10);
      r = cyc;
      bus.btn_n[0] = 1'b1;
      push(1, 0, r + 6);
      go_to(r + 12);
      checks++;
      if (sb.size() != 0 || bus.btn_level !== 2'b00) begin
         failures++;
         $display("[TB] FAIL bounce_pending: got %0d outstanding lvl=%b required 0 lvl=00", sb.size(), bus.btn_level);
         sb.delete();
      end
   endtask

   task automatic test_press_release();
      int c, high;
      c = cyc;
      high = 0;
      bus.btn_n[0] = 1'b0;
      push(0, 0, c + 6);
`ifdef BTN_AUTOREPEAT_EN
      push(0, 0, c + 16);
      push(0, 0, c + 21);
`endif
      for (int t = c + 1; t <= c + 32; t++) begin
         go_to(t);
         if (t == c + 20) begin
            bus.btn_n[0] = 1'b1;
            push(1, 0, c + 26);
         end
         if (bus.btn_level[0] === 1'b1) high++;
      end
      checks++;
      if (high != 20) begin
         failures++;
         $display("[TB] FAIL press_level_width: got %0d cycles required 20", high);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL press_pending: got %0d outstanding required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_combo();
      int c;
      c = cyc;
      bus.btn_n = 2'b00;
      push(0, 0, c + 6);
      push(0, 1, c + 6);
      push(2, 0, c + 13);
      go_to(c + 13);
      checks++;
      if (bus.combo_active !== 1'b0) begin
         failures++;
         $display("[TB] FAIL combo_active_arm: got %b required 0", bus.combo_active);
      end
      go_to(c + 14);
      checks++;
      if (bus.combo_active !== 1'b1) begin
         failures++;
         $display("[TB] FAIL combo_active_fired: got %b required 1", bus.combo_active);
      end
      go_to(c + 30);
      bus.btn_n = 2'b11;
      go_to(c + 36);
      checks++;
      if (bus.btn_level !== 2'b00 || bus.combo_active !== 1'b1) begin
         failures++;
         $display("[TB] FAIL combo_hold: got lvl=%b act=%b required lvl=00 act=1", bus.btn_level, bus.combo_active);
      end
      go_to(c + 37);
      checks++;
      if (bus.combo_active !== 1'b0) begin
         failures++;
         $display("[TB] FAIL combo_exit: got %b required 0", bus.combo_active);
      end
      go_to(c + 42);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL combo_pending: got %0d outstanding required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_combo_abort();
      int c;
      c = cyc;
      bus.btn_n = 2'b00;
      push(0, 0, c + 6);
      push(0, 1, c + 6);
      go_to(c + 4);
      bus.btn_n[1] = 1'b1;
      push(1, 1, c + 10);
`ifdef BTN_AUTOREPEAT_EN
      push(0, 0, c + 16);
      push(0, 0, c + 21);
`endif
      go_to(c + 10);
      checks++;
      if (bus.btn_level !== 2'b01) begin
         failures++;
         $display("[TB] FAIL abort_level: got %b required 01", bus.btn_level);
      end
      go_to(c + 16);
      checks++;
      if (bus.combo_active !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_active: got %b required 0", bus.combo_active);
      end
      bus.btn_n[0] = 1'b1;
      push(1, 0, c + 22);
      go_to(c + 28);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL abort_pending: got %0d outstanding required 0", sb.size());
         sb.delete();
      end
   endtask

`ifdef BTN_AUTOREPEAT_EN
   task automatic test_autorepeat();
      int c, t0;
      c = cyc;
      t0 = c + 6;
      bus.btn_n[0] = 1'b0;
      push(0, 0, t0);
      push(0, 0, t0 + 10);
      push(0, 0, t0 + 15);
      push(0, 0, t0 + 20);
      push(0, 0, t0 + 25);
      go_to(c + 30);
      bus.btn_n[0] = 1'b1;
      push(1, 0, t0 + 30);
      go_to(t0 + 45);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL repeat_pending: got %0d outstanding required 0", sb.size());
         sb.delete();
      end
   endtask
`endif

   initial begin
      bus.btn_n = 2'b11;
      Reset = 1'b1;
      test_reset();
      go_to(cyc + 5);
      test_bounce();
      go_to(cyc + 5);
      test_press_release();
      go_to(cyc + 5);
      test_combo();
      go_to(cyc + 5);
      test_combo_abort();
`ifdef BTN_AUTOREPEAT_EN
      go_to(cyc + 5);
      test_autorepeat();
`endif
      go_to(cyc + 5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
